mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 data multiplexer between four requesters. It owns the mux select lines and grants the mux path to one requester at a time, using a req/gnt handshake. A hold limit forces rotation so that no requester can starve the others. It sits in front of the 4:1 mux datapath and replaces hand-driven s1/s0 select stimulus with sequenced control.

---
 rtl/mux_arb_pkg.sv | 40 ++++
 rtl/mux4_dw.sv | 25 ++
 rtl/mux4_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Result of a round-robin search: winner index plus a found flag.
    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // Search req starting at ptr and wrapping modulo NUM_REQ; first set bit wins.
    function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [SEL_W-1:0]   ptr);
        rr_pick_t         res;
        logic [SEL_W-1:0] cand;
        res.found = 1'b0;
        res.idx   = ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

    // One-hot grant vector for a requester index.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_dw.sv
// DW-wide 4:1 data multiplexer steered by a 2-bit select.
module mux4_dw #(
    parameter int unsigned DW = 8
) (
    input  logic [1:0]    sel,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] d3,
    output logic [DW-1:0] y
);

    // Select one of the four data inputs.
    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 mux, with hold-limit rotation.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [DW-1:0] in_data0,
    input  logic [DW-1:0] in_data1,
    input  logic [DW-1:0] in_data2,
    input  logic [DW-1:0] in_data3,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic          busy,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          preempt
);

    localparam int unsigned HOLD_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit          PREEMPT_EN = (MAX_HOLD != 0);
    // With MAX_HOLD=0 the saturation value is 0, so the counter simply stays idle.
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t          state, state_nxt;
    logic [SEL_W-1:0]    ptr, ptr_nxt;
    logic [HOLD_W-1:0]   hold, hold_nxt;
    logic [NUM_REQ-1:0]  gnt_nxt;
    logic [SEL_W-1:0]    sel_nxt;
    logic                busy_nxt;
    logic                preempt_nxt;

    logic [SEL_W-1:0]    pick_base;
    logic [NUM_REQ-1:0]  pick_req;
    rr_pick_t            pick;
    logic [DW-1:0]       mux_out;

    // Shared datapath mux, steered directly by the registered select.
    mux4_dw #(
        .DW (DW)
    ) u_mux (
        .sel (sel),
        .d0  (in_data0),
        .d1  (in_data1),
        .d2  (in_data2),
        .d3  (in_data3),
        .y   (mux_out)
    );

    // Register all arbiter state and outputs; reset acts immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            hold    <= '0;
            gnt     <= '0;
            sel     <= '0;
            busy    <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            hold    <= hold_nxt;
            gnt     <= gnt_nxt;
            sel     <= sel_nxt;
            busy    <= busy_nxt;
            preempt <= preempt_nxt;
        end
    end

    // Next-state: arbitrate from ptr when idle, from owner+1 (owner masked) when granted.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold;
        gnt_nxt     = gnt;
        sel_nxt     = sel;
        busy_nxt    = busy;
        preempt_nxt = 1'b0;

        pick_base = ptr;
        pick_req  = req;
        if (state == GRANT) begin
            pick_base = sel + SEL_W'(1);
            pick_req  = req & ~onehot(sel);
        end
        pick = rr_pick(pick_req, pick_base);

        case (state)
            IDLE: begin
                if (pick.found) begin
                    state_nxt = GRANT;
                    gnt_nxt   = onehot(pick.idx);
                    sel_nxt   = pick.idx;
                    busy_nxt  = 1'b1;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    // Owner released: advance pointer, hand over with no bubble if possible.
                    ptr_nxt  = pick_base;
                    hold_nxt = '0;
                    if (pick.found) begin
                        gnt_nxt = onehot(pick.idx);
                        sel_nxt = pick.idx;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        busy_nxt  = 1'b0;
                    end
                end else if (PREEMPT_EN && (hold == HOLD_LAST) && pick.found) begin
                    // Hold limit reached with contenders waiting: force rotation.
                    ptr_nxt     = pick_base;
                    gnt_nxt     = onehot(pick.idx);
                    sel_nxt     = pick.idx;
                    hold_nxt    = '0;
                    preempt_nxt = 1'b1;
                end else if (hold != HOLD_SAT) begin
                    hold_nxt = hold + HOLD_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Gated mux output and transfer-valid indication.
    always_comb begin
        out_data  = busy ? mux_out : '0;
        out_valid = busy & req[sel];
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (DW=8, MAX_HOLD=4).
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [7:0] out_data;
    logic       out_valid;
    logic       preempt;

    int compared   = 0;
    int mismatched = 0;

    mux4_rr_arbiter #(
        .DW       (8),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        in_data0 = 8'h11;
        in_data1 = 8'h22;
        in_data2 = 8'h33;
        in_data3 = 8'h44;
        tick();
        rst = 1'b0;

        // 1. Reset mid-grant takes effect without a clock
        req = 4'b0100;
        tick();
        chk("t1_gnt_before_rst", 32'(gnt), 32'(4'b0100));
        chk("t1_sel_before_rst", 32'(sel), 32'(2'b10));
        rst = 1'b1;
        #1;
        chk("t1_gnt_async", 32'(gnt), 32'(4'b0000));
        chk("t1_sel_async", 32'(sel), 32'(2'b00));
        chk("t1_busy_async", 32'(busy), 32'(1'b0));
        chk("t1_out_async", 32'(out_data), 32'(8'h00));
        req = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("t1_idle_gnt", 32'(gnt), 32'(4'b0000));
        chk("t1_idle_busy", 32'(busy), 32'(1'b0));
        chk("t1_idle_valid", 32'(out_valid), 32'(1'b0));
        chk("t1_idle_preempt", 32'(preempt), 32'(1'b0));

        // 2. Single request with combinational data tracking
        req = 4'b0010;
        in_data1 = 8'hA5;
        #1;
        chk("t2_no_early_gnt", 32'(gnt), 32'(4'b0000));
        tick();
        chk("t2_gnt", 32'(gnt), 32'(4'b0010));
        chk("t2_sel", 32'(sel), 32'(2'b01));
        chk("t2_out", 32'(out_data), 32'(8'hA5));
        chk("t2_valid", 32'(out_valid), 32'(1'b1));
        in_data1 = 8'h3C;
        #1;
        chk("t2_out_track", 32'(out_data), 32'(8'h3C));
        req = 4'b0000;
        #1;
        chk("t2_valid_drop", 32'(out_valid), 32'(1'b0));
        tick();
        chk("t2_rel_gnt", 32'(gnt), 32'(4'b0000));
        chk("t2_rel_busy", 32'(busy), 32'(1'b0));
        chk("t2_rel_out", 32'(out_data), 32'(8'h00));
        chk("t2_sel_kept", 32'(sel), 32'(2'b01));

        // 3. Round-robin order 0,1,2,3,0 without bubbles
        pulse_reset();
        req = 4'b1111;
        tick();
        chk("t3_g0", 32'(gnt), 32'(4'b0001));
        req = 4'b1110;
        tick();
        chk("t3_g1", 32'(gnt), 32'(4'b0010));
        chk("t3_busy1", 32'(busy), 32'(1'b1));
        req = 4'b1101;
        tick();
        chk("t3_g2", 32'(gnt), 32'(4'b0100));
        req = 4'b1011;
        tick();
        chk("t3_g3", 32'(gnt), 32'(4'b1000));
        chk("t3_out3", 32'(out_data), 32'(8'h44));
        req = 4'b0111;
        tick();
        chk("t3_g0_again", 32'(gnt), 32'(4'b0001));
        chk("t3_sel0", 32'(sel), 32'(2'b00));
        req = 4'b0000;
        tick();
        chk("t3_idle", 32'(busy), 32'(1'b0));

        // 4. Hold-limit preemption and re-grant
        pulse_reset();
        req = 4'b0100;
        tick();
        chk("t4_own2", 32'(gnt), 32'(4'b0100));
        req = 4'b0101;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("t4_hold_gnt_c%0d", c), 32'(gnt), 32'(4'b0100));
            chk($sformatf("t4_hold_pre_c%0d", c), 32'(preempt), 32'(1'b0));
        end
        tick();
        chk("t4_pre_gnt", 32'(gnt), 32'(4'b0001));
        chk("t4_pre_sel", 32'(sel), 32'(2'b00));
        chk("t4_pre_pulse", 32'(preempt), 32'(1'b1));
        chk("t4_pre_out", 32'(out_data), 32'(8'h11));
        tick();
        chk("t4_pulse_end", 32'(preempt), 32'(1'b0));
        chk("t4_keep0", 32'(gnt), 32'(4'b0001));
        req = 4'b0100;
        tick();
        chk("t4_regrant2", 32'(gnt), 32'(4'b0100));
        chk("t4_regrant_sel", 32'(sel), 32'(2'b10));
        req = 4'b0000;
        tick();

        // 5. Lone requester keeps the grant indefinitely
        pulse_reset();
        req = 4'b1000;
        tick();
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("t5_gnt_c%0d", c), 32'(gnt), 32'(4'b1000));
            chk($sformatf("t5_pre_c%0d", c), 32'(preempt), 32'(1'b0));
            tick();
        end
        req = 4'b0000;
        tick();

        // 6. Release coinciding with new requests: search runs 2,3,0
        pulse_reset();
        req = 4'b0010;
        tick();
        chk("t6_own1", 32'(gnt), 32'(4'b0010));
        req = 4'b1001;
        tick();
        chk("t6_gnt3", 32'(gnt), 32'(4'b1000));
        chk("t6_sel3", 32'(sel), 32'(2'b11));
        chk("t6_out3", 32'(out_data), 32'(8'h44));
        chk("t6_busy", 32'(busy), 32'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
